// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with stride advance, branch/jump redirect,
// one-cycle redirect bubble and a saturating redirect counter.
module pc_sequencer #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned STEP     = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned OFFSET_W = 16,
   parameter int unsigned SHIFT    = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [WIDTH-1:0]    pc,
   output logic                pc_valid,
   input  logic                fetch_ready,
   output logic [WIDTH-1:0]    pc_inc,
   input  logic                branch_req,
   input  logic [WIDTH-1:0]    branch_base,
   input  logic [OFFSET_W-1:0] branch_offset,
   output logic [WIDTH-1:0]    branch_target,
   input  logic                jump_req,
   input  logic [WIDTH-1:0]    jump_target,
   output logic                misalign,
   output logic [CNT_W-1:0]    redirect_cnt
);

   localparam logic [1:0] BOOT   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] BUBBLE = 2'd2;

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ALIGN  = WIDTH'(STEP - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] off_ext;
   logic             mis_nxt;
   logic             bump;

   assign pc_inc  = pc + STEP_W;
   assign off_ext = WIDTH'($signed(branch_offset));
   assign branch_target = branch_base + (off_ext << SHIFT);

   // Redirects are honoured in every state; advance only while presenting.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      mis_nxt   = 1'b0;
      bump      = 1'b0;
      if (jump_req) begin
         pc_nxt    = jump_target & ~ALIGN;
         mis_nxt   = |(jump_target & ALIGN);
         state_nxt = BUBBLE;
         bump      = 1'b1;
      end else if (branch_req) begin
         pc_nxt    = branch_target;
         state_nxt = BUBBLE;
         bump      = 1'b1;
      end else begin
         case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (fetch_ready) pc_nxt = pc_inc;
            BUBBLE:  state_nxt = RUN;
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         pc_valid     <= 1'b0;
         misalign     <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pc_valid <= (state_nxt == RUN);
         misalign <= mis_nxt;
         if (bump && redirect_cnt != '1)
            redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end

endmodule
